conv_fprop3_mul_arbiter: RTL and testbench
==========================================

# conv_fprop3_mul_arbiter

Round-robin arbiter that time-shares one pipelined signed 32×32→32 multiplier between several conv_fprop3 datapath requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the shared multiplier's `ce`/operand inputs. A tag pipeline matched to the multiplier latency routes each truncated product back to its owner through a single backpressured response register. It sits between the convolution MAC lanes and the single `conv_fprop3_mul_32s_32s_32_2_1` instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 32: operand and product width.
- `MUL_LATENCY`, 1: register stages inside the shared multiplier (clock edges with `ce`=1 from operands to `dout`).
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero.
- `req_a`  in  NUM_REQ*DATA_WIDTH  packed operand A, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_b`  in  NUM_REQ*DATA_WIDTH  packed operand B, same packing.
- `rsp_valid`  out  NUM_REQ  one-hot result valid for the owning requester.
- `rsp_ready`  in  NUM_REQ  per-requester result accept.
- `rsp_data`  out  DATA_WIDTH  result, broadcast to all requesters.
- `mul_ce`  out  1  shared multiplier clock enable.
- `mul_din0`, `mul_din1`  out  DATA_WIDTH  shared multiplier operands.
- `mul_dout`  in  DATA_WIDTH  shared multiplier result.
- `busy`  out  1  any operation in flight or held.

## Operation
- `advance = !out_full || rsp_ready[out_tag]`. Drive `mul_ce = advance`.
- Grant: round-robin search over `req_valid`, starting at `rr_ptr`. At most one grant per cycle.
- `req_ready[g] = advance` for the granted index `g`; all other bits are 0.
- `mul_din0`/`mul_din1` = `req_a`/`req_b` of `g`. When there is no grant, they hold the operands of requester `rr_ptr`; their value is a don't-care.
- On handshake (`req_valid[g] && req_ready[g]`), `rr_ptr` becomes `(g+1) mod NUM_REQ`. Otherwise `rr_ptr` holds.
- Tag pipeline: `MUL_LATENCY` stages of {valid, tag}. Stage 0 loads {handshake, g}. It shifts only when `advance`; bubbles shift too.
- Output register: when `advance`, it loads {last-stage valid, last-stage tag, `mul_dout`}. `out_full` is the loaded valid bit.
- `rsp_valid[i] = out_full && out_tag==i`. `rsp_data` holds steady while `out_full` and the response is not accepted.
- Arithmetic: the product is the low `DATA_WIDTH` bits of the signed product. The arbiter forwards `mul_dout` unmodified.
- `busy` = OR of all pipeline valid bits and `out_full`.
- Requesters receive their results in the same order their requests were accepted.

## Timing
- Reset (async assert, sync release): `rr_ptr`=0, all tag valid bits 0, `out_full`=0, `out_tag`=0, `rsp_data`=0.
  - Outputs during reset: `rsp_valid`=0, `busy`=0, `req_ready`=0, `mul_ce`=1.
  - Reset mid-operation discards all in-flight and held results; no response is produced for them.
- Latency: handshake at cycle t → `rsp_valid` at cycle t+MUL_LATENCY+1 when there is no backpressure. Throughput is 1 op/cycle.
- Backpressure: if `out_full` and the owner's `rsp_ready`=0, then `mul_ce`=0 and `req_ready`=0. The multiplier, tag pipe and output register freeze with no data loss.
- Simultaneous accept of the response and a new issue in the same cycle is allowed (full throughput).
- `rsp_ready` of non-owning requesters is ignored.
- `req_valid` deasserting without a handshake is permitted; the arbiter keeps no request state.

## Structure
- Shared package `conv_fprop3_pkg`: `DATA_WIDTH`, the tag width `$clog2(NUM_REQ)`, and the tag/valid stage struct.
- One natural sub-module: `conv_fprop3_rr_arb`. It is a combinational round-robin priority picker plus the `rr_ptr` register with `advance`/handshake update.
- The multiplier stays external and is instantiated by the parent.

## Test plan
- Single request: req0 a=7, b=−3 → `req_ready[0]` in the same cycle. At t+2 (latency 1): `rsp_valid`=0001, `rsp_data`=0xFFFFFFEB.
- All four requesters valid continuously with distinct operands → grants rotate 0,1,2,3,0… One result per cycle; each owner receives the correct product.
- Overflow: a=0x7FFFFFFF, b=2 → `rsp_data`=0xFFFFFFFE (truncated low 32 bits).
- Backpressure: owner holds `rsp_ready`=0 for 5 cycles with 3 ops in flight. Checks: `mul_ce`=0, `req_ready`=0, `rsp_data` stable. After release, all 3 results are delivered in order with none lost.
- Pointer fairness: req2 alone is serviced, then req0..3 all valid → the next grant is 3, then 0.
- Reset asserted mid-stream with `busy`=1 → all outputs return to reset values immediately. After release, no stale `rsp_valid` appears.

Source files
------------

// File: rtl/conv_fprop3_pkg.sv
// Shared types for the conv_fprop3 multiplier arbiter: data width, tag width and
// the {valid, tag} stage that travels alongside the shared multiplier.
package conv_fprop3_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int NUM_REQ_MAX = 8;
    // Sized for the largest supported requester count so one struct serves every build.
    localparam int TAG_W       = $clog2(NUM_REQ_MAX);

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } tag_stage_t;

    function automatic tag_t next_idx(tag_t idx, int num_req);
        return (int'(idx) == num_req - 1) ? '0 : idx + tag_t'(1);
    endfunction

endpackage

// File: rtl/conv_fprop3_mul_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: per-requester operand and result handshakes.
interface conv_fprop3_mul_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    // valid/ready: a beat transfers on a rising clk edge where both valid and ready are 1;
    // operands/results are held by the producer while valid && !ready.
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/conv_fprop3_rr_arb.sv
// Round-robin picker over req_valid starting at rr_ptr; the pointer moves past the
// winner only when the grant is actually taken.
module conv_fprop3_rr_arb
    import conv_fprop3_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               issue_en,
    output logic               grant_valid,
    output tag_t               grant_idx,
    output tag_t               rr_ptr
);

    logic [2*NUM_REQ-1:0] rot;

    // Rotate so bit k of rot is requester (rr_ptr + k) mod NUM_REQ; the first set bit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        rot         = {req_valid, req_valid} >> rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && rot[k]) begin
                grant_valid = 1'b1;
                grant_idx   = tag_t'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (grant_valid && issue_en) begin
            rr_ptr <= next_idx(grant_idx, NUM_REQ);
        end
    end

endmodule

// File: rtl/conv_fprop3_mul_arbiter.sv
// Time-shares one pipelined 32x32 multiplier among NUM_REQ requesters; a tag pipe matched
// to the multiplier latency steers each product back through one backpressured register.
module conv_fprop3_mul_arbiter
    import conv_fprop3_pkg::tag_t;
    import conv_fprop3_pkg::tag_stage_t;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = conv_fprop3_pkg::DATA_WIDTH,
    parameter int MUL_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    conv_fprop3_mul_arbiter_if.slave bus,
    output logic                  mul_ce,
    output logic [DATA_WIDTH-1:0] mul_din0,
    output logic [DATA_WIDTH-1:0] mul_din1,
    input  logic [DATA_WIDTH-1:0] mul_dout,
    output logic                  busy
);

    tag_stage_t            pipe [MUL_LATENCY];
    logic                  out_full;
    tag_t                  out_tag;
    logic [DATA_WIDTH-1:0] out_data;

    logic                  owner_ready;
    logic                  advance;
    logic                  issue_en;
    logic                  handshake;
    logic                  grant_valid;
    tag_t                  grant_idx;
    tag_t                  rr_ptr;
    tag_t                  sel;
    logic [NUM_REQ-1:0]    req_ready_w;
    logic [NUM_REQ-1:0]    rsp_valid_w;

    always_comb begin
        owner_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (out_tag == tag_t'(i)) owner_ready = bus.rsp_ready[i];
        end
    end

    // The whole datapath moves in lockstep: the multiplier, tag pipe and output register
    // all freeze while the held result is refused by its owner.
    assign advance   = !out_full || owner_ready;
    assign mul_ce    = advance;
    assign issue_en  = advance && reset_n;
    assign handshake = grant_valid && issue_en;

    conv_fprop3_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (bus.req_valid),
        .issue_en    (issue_en),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .rr_ptr      (rr_ptr)
    );

    assign sel = grant_valid ? grant_idx : rr_ptr;

    always_comb begin
        mul_din0    = '0;
        mul_din1    = '0;
        req_ready_w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == tag_t'(i)) begin
                mul_din0 = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                mul_din1 = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (handshake && grant_idx == tag_t'(i)) req_ready_w[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MUL_LATENCY; i++) pipe[i] <= '0;
            out_full <= 1'b0;
            out_tag  <= '0;
            out_data <= '0;
        end else if (advance) begin
            // Bubbles shift too, keeping each tag aligned with its product in the multiplier.
            pipe[0] <= {handshake, grant_idx};
            for (int i = 1; i < MUL_LATENCY; i++) pipe[i] <= pipe[i-1];
            out_full <= pipe[MUL_LATENCY-1].valid;
            out_tag  <= pipe[MUL_LATENCY-1].tag;
            out_data <= mul_dout;
        end
    end

    always_comb begin
        rsp_valid_w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_w[i] = out_full && (out_tag == tag_t'(i));
        end
    end

    always_comb begin
        busy = out_full;
        for (int i = 0; i < MUL_LATENCY; i++) busy = busy | pipe[i].valid;
    end

    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = rsp_valid_w;
    assign bus.rsp_data  = out_data;

endmodule

// File: tb/tb_conv_fprop3_mul_arbiter.sv
// Bench for conv_fprop3_mul_arbiter: transaction-level model checked every cycle plus
// directed cases with hand-computed products and grant orders.
module tb_conv_fprop3_mul_arbiter;
    import conv_fprop3_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int L  = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mul_ce;
    logic [DW-1:0] mul_din0;
    logic [DW-1:0] mul_din1;
    logic [DW-1:0] mul_dout;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    conv_fprop3_mul_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    conv_fprop3_mul_arbiter #(
        .NUM_REQ     (N),
        .DATA_WIDTH  (DW),
        .MUL_LATENCY (L)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .mul_ce   (mul_ce),
        .mul_din0 (mul_din0),
        .mul_din1 (mul_din1),
        .mul_dout (mul_dout),
        .busy     (busy)
    );

    // Stand-in for the external shared multiplier: L stages, all gated by ce.
    logic [DW-1:0] mstage [L];
    always @(posedge clk) begin
        if (mul_ce) begin
            mstage[0] <= mul_din0 * mul_din1;
            for (int i = 1; i < L; i++) mstage[i] <= mstage[i-1];
        end
    end
    assign mul_dout = mstage[L-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
    endtask

    // Transaction model: accepted ops queue in order; each needs L more advancing edges
    // after acceptance before it is presented, and leaves when its owner takes it.
    logic [DW-1:0] exp_q[$];
    int            tag_q[$];
    int            cnt_q[$];
    int            ptr_m;
    logic [DW-1:0] got_q[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            tag_q.delete();
            cnt_q.delete();
            ptr_m = 0;
        end else begin
            logic [N-1:0]  e_rv;
            logic [N-1:0]  e_rr;
            logic          stall;
            logic          gv;
            int            g;
            logic [DW-1:0] av;
            logic [DW-1:0] bv;
            e_rv = '0;
            if (exp_q.size() > 0 && cnt_q[0] >= L) e_rv = N'(1) << tag_q[0];
            stall = (e_rv != '0) && ((e_rv & bus.rsp_ready) == '0);
            gv = 1'b0;
            g  = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (ptr_m + k) % N;
                if (!gv && ((bus.req_valid >> j) & N'(1)) != '0) begin
                    gv = 1'b1;
                    g  = j;
                end
            end
            e_rr = (gv && !stall) ? (N'(1) << g) : '0;
            av = DW'(bus.req_a >> (g*DW));
            bv = DW'(bus.req_b >> (g*DW));

            chk("req_ready", 32'(bus.req_ready), 32'(e_rr));
            chk("mul_ce", 32'(mul_ce), 32'(!stall));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
            chk("busy", 32'(busy), 32'(exp_q.size() > 0));
            if (e_rv != '0) chk("rsp_data", bus.rsp_data, exp_q[0]);
            if (gv) begin
                chk("mul_din0", mul_din0, av);
                chk("mul_din1", mul_din1, bv);
            end

            if (!stall) begin
                for (int i = 0; i < cnt_q.size(); i++) cnt_q[i] = cnt_q[i] + 1;
                if (e_rv != '0) begin
                    void'(exp_q.pop_front());
                    void'(tag_q.pop_front());
                    void'(cnt_q.pop_front());
                end
            end
            if (gv && !stall) begin
                exp_q.push_back(av * bv);
                tag_q.push_back(g);
                cnt_q.push_back(0);
                ptr_m = (g + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid[0] && bus.rsp_ready[0]) got_q.push_back(bus.rsp_data);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;

        // Reset values, with a live request to show req_ready stays low.
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = 4'b0001;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_mul_ce", 32'(mul_ce), 32'h1);
        bus.req_valid = '0;
        tick();
        reset_n = 1'b1;
        tick();

        // Single request 7 * -3, result two cycles after the handshake.
        set_op(0, 32'd7, -32'sd3);
        bus.req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        #1;
        chk("single_t1_valid", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("single_t2_valid", 32'(bus.rsp_valid), 32'h1);
        chk("single_data", bus.rsp_data, 32'hFFFF_FFEB);
        tick();

        // Overflow truncates to the low 32 bits.
        set_op(1, 32'h7FFF_FFFF, 32'd2);
        bus.req_valid = 4'b0010;
        #1;
        chk("ovf_ready", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        tick();
        chk("ovf_valid", 32'(bus.rsp_valid), 32'h2);
        chk("ovf_data", bus.rsp_data, 32'hFFFF_FFFE);
        tick();

        // All four valid: pointer sits at 2, so grants go 2,3,0,1,...
        for (int i = 0; i < N; i++) set_op(i, 32'(i * 100 + 3), -32'(i + 5));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rot_grant", 32'(bus.req_ready), 32'(1 << ((2 + k) % 4)));
            tick();
        end
        bus.req_valid = '0;
        repeat (4) tick();

        // Backpressure: two ops in flight, a third waiting, owner refuses for 5 cycles.
        got_q.delete();
        bus.rsp_ready = 4'b1110;
        set_op(0, 32'd10, 32'd11);
        bus.req_valid = 4'b0001;
        #1;
        chk("bp_ready1", 32'(bus.req_ready), 32'h1);
        tick();
        set_op(0, 32'd12, 32'd13);
        #1;
        chk("bp_ready2", 32'(bus.req_ready), 32'h1);
        tick();
        set_op(0, 32'd14, 32'd15);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_mul_ce", 32'(mul_ce), 32'h0);
            chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_rsp_data", bus.rsp_data, 32'd110);
            tick();
        end
        bus.rsp_ready = 4'b1111;
        #1;
        chk("bp_release_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        repeat (6) tick();
        chk("bp_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("bp_order0", got_q[0], 32'd110);
            chk("bp_order1", got_q[1], 32'd156);
            chk("bp_order2", got_q[2], 32'd210);
        end

        // Fairness: after requester 2 alone, the full set continues at 3 then 0.
        set_op(2, 32'd5, 32'd6);
        bus.req_valid = 4'b0100;
        #1;
        chk("fair_req2", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'b1111;
        #1;
        chk("fair_next3", 32'(bus.req_ready), 32'h8);
        tick();
        chk("fair_next0", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        repeat (4) tick();

        // Reset in the middle of a stream.
        bus.req_valid = 4'b1111;
        repeat (3) tick();
        chk("mid_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("mid_rst_mul_ce", 32'(mul_ce), 32'h1);
        bus.req_valid = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
